// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencer controller.
// Optional watchdog is enabled with `define CTRL_WDOG_EN.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ctrl_state_t;

  localparam int              CTR_W      = 4;
  localparam logic [CTR_W-1:0] TERM      = 4'hF;
  localparam int              WDOG_LIMIT = 17;

  // Start value so that the counter hits TERM exactly P cycles after load; P=0 means 16.
  function automatic logic [CTR_W-1:0] period_to_load(input logic [CTR_W-1:0] p);
    logic [CTR_W:0] span;
    span = (CTR_W+1)'(16) - {1'b0, p};
    return span[CTR_W-1:0];
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Requester and counter-datapath signals of the counter sequencer controller.
// master = requesters + counter side, slave = controller.
interface counter_seq_ctrl_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]   req;
  logic [NREQ*4-1:0] req_period;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              ctr_load;
  logic [3:0]        ctr_load_data;
  logic [3:0]        ctr_count;
  logic              wdog_err;

  modport master (
    output req, req_period, ctr_count,
    input  grant, done, busy, ctr_load, ctr_load_data, wdog_err
  );

  modport slave (
    input  req, req_period, ctr_count,
    output grant, done, busy, ctr_load, ctr_load_data, wdog_err
  );

endinterface

// File: rtl/counter_seq_ctrl_rr_arbiter.sv
// Combinational round-robin pick: lowest requester index at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Shares one external loadable 4-bit up-counter among NREQ requesters, one timed job at a time.
// `define CTRL_WDOG_EN adds a RUN-length watchdog with a sticky wdog_err.
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  counter_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  ctrl_state_t      state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CTR_W-1:0] load_q, load_d;

  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [CTR_W-1:0] per_sel;
  logic [NREQ-1:0]  owner_oh;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    per_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_idx == IDX_W'(i)) per_sel = bus.req_period[i*CTR_W +: CTR_W];
  end

`ifdef CTRL_WDOG_EN
  logic [4:0] run_cnt_q, run_cnt_d;
  logic       wdog_q, wdog_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_q <= '0;
      wdog_q    <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      wdog_q    <= wdog_d;
    end
  end

  assign bus.wdog_err = wdog_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      load_q   <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    load_d   = load_q;
`ifdef CTRL_WDOG_EN
    run_cnt_d = '0;
    wdog_d    = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        // Period is captured here; later req_period changes do not affect the job.
        if (arb_any) begin
          owner_d  = arb_idx;
          load_d   = period_to_load(per_sel);
          rr_ptr_d = (arb_idx == IDX_W'(NREQ-1)) ? '0 : arb_idx + IDX_W'(1);
          state_d  = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.ctr_count == TERM) state_d = DONE;
`ifdef CTRL_WDOG_EN
        else if (run_cnt_q == 5'(WDOG_LIMIT-1)) begin
          state_d = IDLE;
          wdog_d  = 1'b1;
        end else run_cnt_d = run_cnt_q + 5'd1;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.grant         = (state_q != IDLE) ? owner_oh : '0;
  assign bus.done          = (state_q == DONE) ? owner_oh : '0;
  assign bus.ctr_load      = (state_q == LOAD);
  assign bus.ctr_load_data = (state_q == LOAD) ? load_q : '0;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with a behavioural 4-bit loadable counter.
// Watchdog section is active when CTRL_WDOG_EN is defined.
module tb_counter_seq_ctrl;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stuck = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_seq_ctrl_if #(.NREQ(NREQ)) bus ();

  counter_seq_ctrl #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // counter_4bit stand-in; 'stuck' pins the count to 3 to starve the terminal count
  always @(posedge clk or negedge reset_n)
    if (!reset_n)          bus.ctr_count <= 4'h0;
    else if (stuck)        bus.ctr_count <= 4'h3;
    else if (bus.ctr_load) bus.ctr_count <= bus.ctr_load_data;
    else                   bus.ctr_count <= bus.ctr_count + 4'd1;

  typedef struct {
    logic [1:0] req;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [1:0] gnt;
    logic [3:0] load;
    int         plen;
  } vec_t;

  typedef struct {
    logic [1:0] gnt;
    int         cyc;
  } sb_t;

  vec_t tbl[5];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    if (k == 40) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: busy still %b after 40 cycles, expected 0", bus.busy);
    end
  endtask

  // Consumes one done pulse and checks it against the oldest scoreboard entry.
  task automatic wait_done(input string nm);
    int  k;
    sb_t e;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done != 2'b00) break;
    end
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_unexpected: done %b with empty scoreboard", nm, bus.done);
    end else begin
      e = sb.pop_front();
      if (k == 40) begin
        n_vec++; n_err++;
        $display("FAIL %s_timeout: no done in 40 cycles, expected %b at cycle %0d", nm, e.gnt, e.cyc);
      end else begin
        chk({nm, "_vec"}, 32'(bus.done), 32'(e.gnt));
        chk({nm, "_cyc"}, cyc, e.cyc);
        bus.req = bus.req & ~bus.done;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t;
    wait_idle();
    bus.req_period = {v.p1, v.p0};
    bus.req        = v.req;
    t = cyc;
    sb.push_back('{v.gnt, t + 2 + v.plen});
    @(negedge clk);
    chk({nm, "_load"},  32'(bus.ctr_load), 32'd1);
    chk({nm, "_ldata"}, 32'(bus.ctr_load_data), 32'(v.load));
    chk({nm, "_grant"}, 32'(bus.grant), 32'(v.gnt));
    bus.req_period = ~{v.p1, v.p0};
    @(negedge clk);
    chk({nm, "_run_ldata"}, 32'({bus.ctr_load, bus.ctr_load_data}), 32'd0);
    chk({nm, "_run_busy"},  32'(bus.busy), 32'd1);
    wait_done(nm);
    @(negedge clk);
    chk({nm, "_idle_busy"},  32'(bus.busy), 32'd0);
    chk({nm, "_idle_grant"}, 32'(bus.grant), 32'd0);
  endtask

  task automatic run_joint(input logic [1:0] first, input logic [1:0] second, input string nm);
    int t;
    wait_idle();
    bus.req_period = {4'h2, 4'h2};
    bus.req        = 2'b11;
    t = cyc;
    sb.push_back('{first,  t + 4});
    sb.push_back('{second, t + 9});
    @(negedge clk);
    chk({nm, "_grant1"}, 32'(bus.grant), 32'(first));
    wait_done({nm, "_a"});
    repeat (2) @(negedge clk);
    chk({nm, "_grant2"}, 32'(bus.grant), 32'(second));
    wait_done({nm, "_b"});
  endtask

  initial begin
    int t;
    logic seen;
    tbl[0] = '{2'b01, 4'h5, 4'h0, 2'b01, 4'hB, 5};
    tbl[1] = '{2'b10, 4'h0, 4'h0, 2'b10, 4'h0, 16};
    tbl[2] = '{2'b01, 4'h1, 4'h0, 2'b01, 4'hF, 1};
    tbl[3] = '{2'b10, 4'h0, 4'hA, 2'b10, 4'h6, 10};
    tbl[4] = '{2'b01, 4'hF, 4'h0, 2'b01, 4'h1, 15};

    bus.req = '0;
    bus.req_period = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_load",  32'(bus.ctr_load), 32'd0);
    chk("rst_ldata", 32'(bus.ctr_load_data), 32'd0);
    chk("rst_wdog",  32'(bus.wdog_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_joint(2'b01, 2'b10, "joint1");

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // last table owner was 0, so the pointer now favours requester 1
    run_joint(2'b10, 2'b01, "joint2");

    // requester drops req mid-job; job still completes, no regrant afterwards
    wait_idle();
    bus.req_period = {4'h0, 4'h6};
    bus.req = 2'b01;
    t = cyc;
    sb.push_back('{2'b01, t + 8});
    repeat (3) @(negedge clk);
    bus.req = 2'b00;
    wait_done("drop");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.grant != 2'b00) seen = 1'b1;
    end
    chk("drop_no_regrant", 32'(seen), 32'd0);

    // async reset in the middle of RUN
    bus.req_period = {4'h0, 4'h8};
    bus.req = 2'b01;
    repeat (3) @(negedge clk);
    chk("rstrun_busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstrun_grant", 32'(bus.grant), 32'd0);
    chk("rstrun_busy",  32'(bus.busy), 32'd0);
    chk("rstrun_load",  32'(bus.ctr_load), 32'd0);
    bus.req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    chk("rstrun_no_done", 32'(seen), 32'd0);
    run_vec(tbl[0], "post_rst");

`ifdef CTRL_WDOG_EN
    wait_idle();
    stuck = 1'b1;
    bus.req_period = {4'h0, 4'h5};
    bus.req = 2'b01;
    seen = 1'b0;
    repeat (18) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    chk("wdog_still_run", 32'(bus.busy), 32'd1);
    chk("wdog_not_yet",   32'(bus.wdog_err), 32'd0);
    @(negedge clk);
    bus.req = 2'b00;
    chk("wdog_err",   32'(bus.wdog_err), 32'd1);
    chk("wdog_idle",  32'(bus.busy), 32'd0);
    chk("wdog_grant", 32'(bus.grant), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    chk("wdog_no_done", 32'(seen), 32'd0);
    chk("wdog_sticky",  32'(bus.wdog_err), 32'd1);
    stuck = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("wdog_cleared", 32'(bus.wdog_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`else
    chk("wdog_tied_low", 32'(bus.wdog_err), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
